// File: rtl/debug_reg_agent.sv
// JTAG debug-hub module that decodes user-DR commands into single req/ack register-bus
// transactions. Optional ack timeout is enabled with `define DEBUG_AGENT_TIMEOUT_EN.
module debug_reg_agent #(
    parameter int DR_WIDTH   = 64,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  bscan_TCK,
    input  logic                  bscan_RESET,
    input  logic                  bscan_SEL,
    input  logic                  bscan_CAPTURE,
    input  logic                  bscan_SHIFT,
    input  logic                  bscan_UPDATE,
    input  logic                  bscan_TDI,
    input  logic                  edb_module_select,
    input  logic [DR_WIDTH-1:0]   edb_user_dr,
    output logic                  edb_module_inhibit,
    output logic                  edb_module_tdo,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic                  bus_ack,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    input  logic                  bus_err
);

    localparam int SR_W = DATA_WIDTH + 3;
    localparam logic [1:0] OP_NOP       = 2'b00;
    localparam logic [1:0] OP_WRITE     = 2'b10;
    localparam logic [1:0] OP_READ_NEXT = 2'b11;

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_bus_we;
    logic [ADDR_WIDTH-1:0] r_bus_addr;
    logic [DATA_WIDTH-1:0] r_bus_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err_sticky;
    logic                  r_ovr_sticky;
    logic [SR_W-1:0]       r_status_sr;

    logic                  w_accept;
    logic [1:0]            w_opcode;
    logic [ADDR_WIDTH-1:0] w_cmd_addr;
    logic [DATA_WIDTH-1:0] w_cmd_wdata;
    logic                  w_start;
    logic                  w_nop;
    logic                  w_overrun;
    logic                  w_ack_done;
    logic                  w_timeout;
    logic                  w_busy;
    logic                  w_unused;

    // A word with the MSB set belongs to the hub's own module-select protocol.
    assign w_accept    = bscan_SEL && bscan_UPDATE && edb_module_select && !edb_user_dr[DR_WIDTH-1];
    assign w_opcode    = edb_user_dr[DR_WIDTH-2 -: 2];
    assign w_cmd_addr  = edb_user_dr[DR_WIDTH-4 -: ADDR_WIDTH];
    assign w_cmd_wdata = edb_user_dr[DATA_WIDTH-1:0];
    assign w_busy      = (r_state == S_REQ);
    assign w_start     = w_accept && !w_busy && (w_opcode != OP_NOP);
    assign w_nop       = w_accept && !w_busy && (w_opcode == OP_NOP);
    assign w_overrun   = w_accept && w_busy;
    assign w_ack_done  = w_busy && bus_ack;
    assign w_unused    = ^{edb_user_dr, TIMEOUT == 0};

`ifdef DEBUG_AGENT_TIMEOUT_EN
    logic [15:0] r_wait_cnt;

    // Terminal cycle is the TIMEOUT-th REQ cycle, so req is high exactly TIMEOUT cycles.
    assign w_timeout = w_busy && !bus_ack && (r_wait_cnt == 16'(TIMEOUT - 1));

    always_ff @(posedge bscan_TCK or posedge bscan_RESET) begin
        if (bscan_RESET) begin
            r_wait_cnt <= '0;
        end else if (w_start) begin
            r_wait_cnt <= '0;
        end else if (w_busy && !bus_ack) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge bscan_TCK or posedge bscan_RESET) begin
        if (bscan_RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_next = S_REQ;
            S_REQ:   if (bus_ack || w_timeout) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge bscan_TCK or posedge bscan_RESET) begin
        if (bscan_RESET) begin
            r_bus_we     <= 1'b0;
            r_bus_addr   <= '0;
            r_bus_wdata  <= '0;
            r_rdata      <= '0;
            r_err_sticky <= 1'b0;
            r_ovr_sticky <= 1'b0;
        end else begin
            // Bus fields only load when leaving IDLE, so they hold steady during REQ.
            if (w_start) begin
                r_bus_we    <= (w_opcode == OP_WRITE);
                r_bus_addr  <= (w_opcode == OP_READ_NEXT) ? r_bus_addr + ADDR_WIDTH'(1) : w_cmd_addr;
                r_bus_wdata <= w_cmd_wdata;
            end
            if (w_ack_done && !r_bus_we) begin
                r_rdata <= bus_rdata;
            end else if (w_timeout) begin
                r_rdata <= '1;
            end
            if (w_nop) begin
                r_err_sticky <= 1'b0;
                r_ovr_sticky <= 1'b0;
            end else begin
                if (w_overrun) r_ovr_sticky <= 1'b1;
                if ((w_ack_done && bus_err) || w_timeout) r_err_sticky <= 1'b1;
            end
        end
    end

    always_ff @(posedge bscan_TCK or posedge bscan_RESET) begin
        if (bscan_RESET) begin
            r_status_sr <= '0;
        end else if (bscan_SEL && bscan_CAPTURE && edb_module_select) begin
            r_status_sr <= {r_ovr_sticky, r_err_sticky, w_busy, r_rdata};
        end else if (bscan_SEL && bscan_SHIFT && edb_module_select) begin
            r_status_sr <= {bscan_TDI, r_status_sr[SR_W-1:1]};
        end
    end

    assign bus_req            = w_busy;
    assign edb_module_inhibit = w_busy;
    assign bus_we             = r_bus_we;
    assign bus_addr           = r_bus_addr;
    assign bus_wdata          = r_bus_wdata;
    assign edb_module_tdo     = r_status_sr[0];

endmodule
